axi_lite_reg_bridge: RTL and testbench
======================================

# axi_lite_reg_bridge

AXI-Lite slave endpoint that terminates one `axi_lite_channel` (slave modport) and converts each transaction into a single-beat request on a simple register-file port. It is the stage directly downstream of an AXI-Lite master or interconnect and directly upstream of peripheral register banks. It buffers AW, W and AR independently, serialises reads and writes, and returns OKAY/SLVERR/DECERR responses.

## Interface
- ADDR_WIDTH, 48, AXI address width; must match the connected channel.
- DATA_WIDTH, 64, AXI data width; must match the channel, 32 or 64 only.
- REG_ADDR_WIDTH, 10, word-address width of the register port.

- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- s  interface  axi_lite_channel.slave  AXI-Lite slave side.
- reg_req  output  1  register access request; held until reg_ready.
- reg_we  output  1  1 = write, 0 = read.
- reg_addr  output  REG_ADDR_WIDTH  word address = axaddr[REG_ADDR_WIDTH+OFS-1:OFS], OFS = log2(DATA_WIDTH/8).
- reg_wdata  output  DATA_WIDTH  write data.
- reg_wstrb  output  DATA_WIDTH/8  byte strobes.
- reg_ready  input  1  access complete this cycle.
- reg_rdata  input  DATA_WIDTH  read data, sampled when reg_req & reg_ready & !reg_we.
- reg_err  input  1  slave error, sampled with reg_ready.

## Operation
- Three holding registers (AW, W, AR), each with a full flag. aw_ready = !aw_full & !rst; w_ready, ar_ready likewise. AW and W are accepted independently, in either order or the same cycle.
- aw_prot/ar_prot are ignored.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: write eligible when aw_full & w_full; read eligible when ar_full. Arbitration is per Configuration. If the selected address has any nonzero bit above REG_ADDR_WIDTH+OFS, go directly to RESP with DECERR (2'b11) and issue no reg_req. Otherwise go to ACCESS.
- ACCESS: reg_req=1; reg_we, reg_addr, reg_wdata and reg_wstrb are stable from the holding registers. On reg_ready: latch resp = reg_err ? SLVERR (2'b10) : OKAY (2'b00); for reads also latch reg_rdata; go to RESP.
- RESP: drive b_valid (write) or r_valid (read) with the latched resp/r_data, held stable until the handshake. On the handshake, clear the consumed holding registers (AW+W, or AR) and return to IDLE.
- r_data is 0 on a DECERR read.
- Exactly one transaction is in flight; responses are in issue order.

## Timing
- Reset values: reg_req=0, reg_we=0, b_valid=0, r_valid=0, b_resp=0, r_resp=0, r_data=0. aw_ready, w_ready and ar_ready are 0 while rst is high and 1 in the first cycle after.
- Zero-wait register (reg_ready tied 1): address+data handshake in cycle N, reg_req in N+1, b_valid/r_valid in N+2.
- Minimum 3 cycles per transaction. A freed holding register may accept a new beat in the cycle after the B/R handshake.
- reg_req never drops before reg_ready, and never asserts in RESP.
- Reset mid-operation: the transaction is discarded with no response; reg_req and valids are 0 from the cycle after rst is sampled high.
- Simultaneous B/R ready with a new AW/AR valid: the response completes, and the new beat is accepted only if its buffer was already empty.

## Configuration
- AXI_LITE_REG_BRIDGE_RR_ARB_EN defined: when read and write are both eligible in IDLE, a 1-bit round-robin pointer alternates priority. The pointer resets to favour write and toggles after each granted transaction.
- Undefined: write always has fixed priority over read.

## Test plan
- Single write, addr 0x10, data 0x1122334455667788, strb 0xFF, reg_ready=1: reg_req in N+1 with reg_addr=2, we=1; b_valid in N+2 with b_resp=00.
- W sent 3 cycles before AW: no reg_req until AW accepted; then identical write issued. Read with reg_ready delayed 4 cycles and reg_err=1: r_resp=10, r_data=latched reg_rdata.
- Read at addr 0x1_0000 (above REG_ADDR_WIDTH window): no reg_req; r_valid with r_resp=11, r_data=0.
- Write and read pending simultaneously, 4 rounds: without macro, all writes first; with macro, grants alternate W,R,W,R.
- rst asserted while in ACCESS with reg_ready=0: next cycle reg_req=0, no B issued; after release, a fresh write completes normally. b_ready held 0 for 5 cycles: b_valid and b_resp remain stable, aw_ready stays 0.

Source files
------------

// File: rtl/axi_lite_reg_bridge_if.sv
// AXI-Lite channel bundle (AW, W, B, AR, R) with master and slave views.
interface axi_lite_channel #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    b_valid;
  logic                    b_ready;
  logic [1:0]              b_resp;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic                    r_valid;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;

  modport master (
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
           ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_lite_reg_bridge.sv
// AXI-Lite slave to single-beat register port bridge, one transaction in flight.
// Optional macro AXI_LITE_REG_BRIDGE_RR_ARB_EN: round-robin read/write arbitration.
module axi_lite_reg_bridge #(
  parameter int ADDR_WIDTH     = 48,
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_lite_channel.slave            s,
  output logic                      reg_req,
  output logic                      reg_we,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  output logic [DATA_WIDTH/8-1:0]   reg_wstrb,
  input  logic                      reg_ready,
  input  logic [DATA_WIDTH-1:0]     reg_rdata,
  input  logic                      reg_err
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFS    = $clog2(STRB_W);
  localparam int HI     = REG_ADDR_WIDTH + OFS;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state;
  logic                    cur_we;
  logic                    aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, ar_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_W-1:0]       w_strb_q;
  logic                    b_valid_q, r_valid_q;
  logic [1:0]              b_resp_q, r_resp_q;
  logic [DATA_WIDTH-1:0]   r_data_q;

  logic                    aw_hs, w_hs, ar_hs;
  logic                    wr_elig, rd_elig, grant_wr, grant_rd;
  logic [ADDR_WIDTH-1:0]   wr_addr_eff, rd_addr_eff, sel_addr;
  logic                    unused_prot;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> HI) == '0;
  endfunction

  function automatic logic [1:0] access_resp(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

  assign s.aw_ready = !aw_full && !rst;
  assign s.w_ready  = !w_full  && !rst;
  assign s.ar_ready = !ar_full && !rst;
  assign s.b_valid  = b_valid_q;
  assign s.b_resp   = b_resp_q;
  assign s.r_valid  = r_valid_q;
  assign s.r_resp   = r_resp_q;
  assign s.r_data   = r_data_q;

  assign aw_hs = s.aw_valid && s.aw_ready;
  assign w_hs  = s.w_valid  && s.w_ready;
  assign ar_hs = s.ar_valid && s.ar_ready;

  // Beats arriving this cycle count as buffered so a zero-wait access issues next cycle.
  assign wr_elig     = (aw_full || aw_hs) && (w_full || w_hs);
  assign rd_elig     = ar_full || ar_hs;
  assign wr_addr_eff = aw_full ? aw_addr_q : s.aw_addr;
  assign rd_addr_eff = ar_full ? ar_addr_q : s.ar_addr;

`ifdef AXI_LITE_REG_BRIDGE_RR_ARB_EN
  logic rr_ptr;  // 0 favours write, 1 favours read
  assign grant_wr = wr_elig && (!rd_elig || !rr_ptr);

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= 1'b0;
    else if (state == IDLE && (wr_elig || rd_elig))
      rr_ptr <= ~rr_ptr;
  end
`else
  assign grant_wr = wr_elig;
`endif

  assign grant_rd = rd_elig && !grant_wr;
  assign sel_addr = grant_wr ? wr_addr_eff : rd_addr_eff;

  assign reg_we    = cur_we;
  assign reg_addr  = cur_we ? aw_addr_q[HI-1:OFS] : ar_addr_q[HI-1:OFS];
  assign reg_wdata = w_data_q;
  assign reg_wstrb = w_strb_q;

  assign unused_prot = ^{s.aw_prot, s.ar_prot};

  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr_q <= s.aw_addr;
    if (w_hs) begin
      w_data_q <= s.w_data;
      w_strb_q <= s.w_strb;
    end
    if (ar_hs) ar_addr_q <= s.ar_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_we    <= 1'b0;
      reg_req   <= 1'b0;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      ar_full   <= 1'b0;
      b_valid_q <= 1'b0;
      r_valid_q <= 1'b0;
      b_resp_q  <= 2'b00;
      r_resp_q  <= 2'b00;
      r_data_q  <= '0;
    end else begin
      if (aw_hs) aw_full <= 1'b1;
      if (w_hs)  w_full  <= 1'b1;
      if (ar_hs) ar_full <= 1'b1;

      case (state)
        IDLE: begin
          if (grant_wr || grant_rd) begin
            cur_we <= grant_wr;
            if (addr_in_range(sel_addr)) begin
              state   <= ACCESS;
              reg_req <= 1'b1;
            end else begin
              // Out-of-window address: answer without touching the register port.
              state <= RESP;
              if (grant_wr) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= RESP_DECERR;
              end else begin
                r_valid_q <= 1'b1;
                r_resp_q  <= RESP_DECERR;
                r_data_q  <= '0;
              end
            end
          end
        end

        ACCESS: begin
          if (reg_ready) begin
            reg_req <= 1'b0;
            state   <= RESP;
            if (cur_we) begin
              b_valid_q <= 1'b1;
              b_resp_q  <= access_resp(reg_err);
            end else begin
              r_valid_q <= 1'b1;
              r_resp_q  <= access_resp(reg_err);
              r_data_q  <= reg_rdata;
            end
          end
        end

        RESP: begin
          if (cur_we && s.b_ready) begin
            b_valid_q <= 1'b0;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            state     <= IDLE;
          end else if (!cur_we && s.r_ready) begin
            r_valid_q <= 1'b0;
            ar_full   <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Directed self-checking bench for axi_lite_reg_bridge.
module tb_axi_lite_reg_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        reg_req, reg_we;
  logic [9:0]  reg_addr;
  logic [63:0] reg_wdata;
  logic [7:0]  reg_wstrb;
  logic        reg_ready;
  logic [63:0] reg_rdata;
  logic        reg_err;

  int n_checks = 0;
  int n_fail   = 0;

  axi_lite_channel #(.ADDR_WIDTH(48), .DATA_WIDTH(64)) s_if ();

  axi_lite_reg_bridge #(.ADDR_WIDTH(48), .DATA_WIDTH(64), .REG_ADDR_WIDTH(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (s_if),
    .reg_req   (reg_req),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wstrb (reg_wstrb),
    .reg_ready (reg_ready),
    .reg_rdata (reg_rdata),
    .reg_err   (reg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       aw_hs, w_hs, ar_hs, b_hs, r_hs;
    int         aw_n, w_n, ar_n, grants, resps;
    logic [7:0] order;
    logic [7:0] exp_order;

    rst = 1'b1;
    reg_ready = 1'b1; reg_rdata = '0; reg_err = 1'b0;
    s_if.aw_valid = 1'b0; s_if.aw_addr = '0; s_if.aw_prot = 3'b000;
    s_if.w_valid  = 1'b0; s_if.w_data  = '0; s_if.w_strb  = '0;
    s_if.ar_valid = 1'b0; s_if.ar_addr = '0; s_if.ar_prot = 3'b000;
    s_if.b_ready  = 1'b1; s_if.r_ready = 1'b1;

    tick(); tick(); tick();
    chk("rst_aw_ready", 64'(s_if.aw_ready), 64'd0);
    chk("rst_w_ready",  64'(s_if.w_ready),  64'd0);
    chk("rst_ar_ready", 64'(s_if.ar_ready), 64'd0);
    chk("rst_reg_req",  64'(reg_req), 64'd0);
    chk("rst_reg_we",   64'(reg_we), 64'd0);
    chk("rst_b_valid",  64'(s_if.b_valid), 64'd0);
    chk("rst_r_valid",  64'(s_if.r_valid), 64'd0);
    chk("rst_b_resp",   64'(s_if.b_resp), 64'd0);
    chk("rst_r_resp",   64'(s_if.r_resp), 64'd0);
    chk("rst_r_data",   s_if.r_data, 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_aw_ready", 64'(s_if.aw_ready), 64'd1);
    chk("post_rst_w_ready",  64'(s_if.w_ready),  64'd1);
    chk("post_rst_ar_ready", 64'(s_if.ar_ready), 64'd1);

    // Single zero-wait write to 0x10
    s_if.aw_valid = 1'b1; s_if.aw_addr = 48'h10;
    s_if.w_valid = 1'b1; s_if.w_data = 64'h1122334455667788; s_if.w_strb = 8'hFF;
    tick();
    s_if.aw_valid = 1'b0; s_if.w_valid = 1'b0;
    chk("wr1_req",   64'(reg_req), 64'd1);
    chk("wr1_we",    64'(reg_we), 64'd1);
    chk("wr1_addr",  64'(reg_addr), 64'd2);
    chk("wr1_wdata", reg_wdata, 64'h1122334455667788);
    chk("wr1_wstrb", 64'(reg_wstrb), 64'hFF);
    chk("wr1_bvalid_early", 64'(s_if.b_valid), 64'd0);
    tick();
    chk("wr1_bvalid", 64'(s_if.b_valid), 64'd1);
    chk("wr1_bresp",  64'(s_if.b_resp), 64'd0);
    chk("wr1_req_off", 64'(reg_req), 64'd0);
    tick();
    chk("wr1_bvalid_done", 64'(s_if.b_valid), 64'd0);

    // W three cycles ahead of AW
    s_if.w_valid = 1'b1; s_if.w_data = 64'hA5A5_5A5A_0F0F_F0F0; s_if.w_strb = 8'h0F;
    tick();
    s_if.w_valid = 1'b0;
    chk("wfirst_w_ready", 64'(s_if.w_ready), 64'd0);
    chk("wfirst_req0", 64'(reg_req), 64'd0);
    tick();
    chk("wfirst_req1", 64'(reg_req), 64'd0);
    tick();
    chk("wfirst_req2", 64'(reg_req), 64'd0);
    s_if.aw_valid = 1'b1; s_if.aw_addr = 48'h28;
    tick();
    s_if.aw_valid = 1'b0;
    chk("wfirst_req",   64'(reg_req), 64'd1);
    chk("wfirst_we",    64'(reg_we), 64'd1);
    chk("wfirst_addr",  64'(reg_addr), 64'd5);
    chk("wfirst_wdata", reg_wdata, 64'hA5A5_5A5A_0F0F_F0F0);
    chk("wfirst_wstrb", 64'(reg_wstrb), 64'h0F);
    tick();
    chk("wfirst_bvalid", 64'(s_if.b_valid), 64'd1);
    chk("wfirst_bresp",  64'(s_if.b_resp), 64'd0);
    tick();
    chk("wfirst_bvalid_done", 64'(s_if.b_valid), 64'd0);

    // Read with slow register port and slave error
    reg_ready = 1'b0;
    s_if.ar_valid = 1'b1; s_if.ar_addr = 48'h40;
    tick();
    s_if.ar_valid = 1'b0;
    chk("rd_req",  64'(reg_req), 64'd1);
    chk("rd_we",   64'(reg_we), 64'd0);
    chk("rd_addr", 64'(reg_addr), 64'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_req_hold", 64'(reg_req), 64'd1);
      chk("rd_rvalid_wait", 64'(s_if.r_valid), 64'd0);
    end
    reg_ready = 1'b1; reg_err = 1'b1; reg_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    reg_err = 1'b0; reg_rdata = 64'h0123_4567_89AB_CDEF;
    chk("rd_rvalid", 64'(s_if.r_valid), 64'd1);
    chk("rd_rresp",  64'(s_if.r_resp), 64'd2);
    chk("rd_rdata",  s_if.r_data, 64'hDEAD_BEEF_CAFE_F00D);
    chk("rd_req_off", 64'(reg_req), 64'd0);
    tick();
    chk("rd_rvalid_done", 64'(s_if.r_valid), 64'd0);

    // Read outside the register window
    reg_rdata = 64'h1234;
    s_if.ar_valid = 1'b1; s_if.ar_addr = 48'h1_0000;
    tick();
    s_if.ar_valid = 1'b0;
    chk("dec_req",    64'(reg_req), 64'd0);
    chk("dec_rvalid", 64'(s_if.r_valid), 64'd1);
    chk("dec_rresp",  64'(s_if.r_resp), 64'd3);
    chk("dec_rdata",  s_if.r_data, 64'd0);
    tick();
    chk("dec_rvalid_done", 64'(s_if.r_valid), 64'd0);
    chk("dec_req_after", 64'(reg_req), 64'd0);

    // Four writes and four reads competing
    aw_n = 0; w_n = 0; ar_n = 0; grants = 0; resps = 0; order = '0;
    s_if.aw_valid = 1'b1; s_if.aw_addr = 48'h0;
    s_if.w_valid  = 1'b1; s_if.w_data = 64'h0; s_if.w_strb = 8'hFF;
    s_if.ar_valid = 1'b1; s_if.ar_addr = 48'h200;
    for (int cyc = 0; cyc < 200 && resps < 8; cyc++) begin
      aw_hs = s_if.aw_valid && s_if.aw_ready;
      w_hs  = s_if.w_valid  && s_if.w_ready;
      ar_hs = s_if.ar_valid && s_if.ar_ready;
      b_hs  = s_if.b_valid  && s_if.b_ready;
      r_hs  = s_if.r_valid  && s_if.r_ready;
      tick();
      if (aw_hs) begin
        aw_n++;
        if (aw_n == 4) s_if.aw_valid = 1'b0;
        s_if.aw_addr = 48'(aw_n * 8);
      end
      if (w_hs) begin
        w_n++;
        if (w_n == 4) s_if.w_valid = 1'b0;
        s_if.w_data = 64'(w_n);
      end
      if (ar_hs) begin
        ar_n++;
        if (ar_n == 4) s_if.ar_valid = 1'b0;
        s_if.ar_addr = 48'(48'h200 + ar_n * 8);
      end
      if (b_hs || r_hs) resps++;
      if (reg_req && grants < 8) begin
        order[grants] = reg_we;
        grants++;
      end
    end
`ifdef AXI_LITE_REG_BRIDGE_RR_ARB_EN
    exp_order = 8'h55;
`else
    exp_order = 8'h0F;
`endif
    chk("arb_resps",  64'(resps), 64'd8);
    chk("arb_grants", 64'(grants), 64'd8);
    chk("arb_order",  64'(order), 64'(exp_order));

    // Reset while the register access is outstanding
    reg_ready = 1'b0;
    s_if.aw_valid = 1'b1; s_if.aw_addr = 48'h18;
    s_if.w_valid = 1'b1; s_if.w_data = 64'hFFFF_0000_FFFF_0000; s_if.w_strb = 8'hF0;
    tick();
    s_if.aw_valid = 1'b0; s_if.w_valid = 1'b0;
    chk("mrst_req_before", 64'(reg_req), 64'd1);
    rst = 1'b1;
    tick();
    chk("mrst_req",    64'(reg_req), 64'd0);
    chk("mrst_bvalid", 64'(s_if.b_valid), 64'd0);
    rst = 1'b0;
    reg_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_no_b", 64'(s_if.b_valid), 64'd0);
      chk("mrst_no_req", 64'(reg_req), 64'd0);
    end
    chk("mrst_aw_ready", 64'(s_if.aw_ready), 64'd1);

    // Fresh write with slave error and a stalled B channel
    reg_err = 1'b1; s_if.b_ready = 1'b0;
    s_if.aw_valid = 1'b1; s_if.aw_addr = 48'h30;
    s_if.w_valid = 1'b1; s_if.w_data = 64'h0BAD_F00D_0BAD_F00D; s_if.w_strb = 8'h3C;
    tick();
    s_if.w_valid = 1'b0; s_if.aw_addr = 48'h38;
    reg_err = 1'b0;
    chk("fresh_req",  64'(reg_req), 64'd1);
    chk("fresh_addr", 64'(reg_addr), 64'd6);
    chk("fresh_wdata", reg_wdata, 64'h0BAD_F00D_0BAD_F00D);
    reg_err = 1'b1;
    tick();
    reg_err = 1'b0;
    chk("fresh_bvalid", 64'(s_if.b_valid), 64'd1);
    chk("fresh_bresp",  64'(s_if.b_resp), 64'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_bvalid",   64'(s_if.b_valid), 64'd1);
      chk("stall_bresp",    64'(s_if.b_resp), 64'd2);
      chk("stall_aw_ready", 64'(s_if.aw_ready), 64'd0);
      chk("stall_req",      64'(reg_req), 64'd0);
    end
    s_if.aw_valid = 1'b0;
    s_if.b_ready = 1'b1;
    tick();
    chk("stall_bvalid_done", 64'(s_if.b_valid), 64'd0);
    chk("stall_aw_ready_free", 64'(s_if.aw_ready), 64'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
